retire_checker: RTL and testbench
=================================

// Module: retire_checker
// PURPOSE
//  Synthesizable self-checking monitor for the pipelined processor. It replaces hand-read $display benches.
//  Observes the WB register-file write port and the MEM data-memory store port, and compares each event
//  in order against an expected-event queue loaded beforehand. Counts cycles and reports PASS, FAIL or TIMEOUT.
//  Sits beside Top; it is driven by the same clock and taps the WB/MEM buses.
// PARAMETERS
//  DATA_W      32   width of register/memory data
//  MADDR_W     32   width of data-memory byte address
//  RADDR_W     5    register index width
//  EXP_DEPTH   16   expected-event queue depth (power of 2, >=2)
//  MAX_CYCLES  256  RUN-state cycle budget before timeout
// PORTS
//  clk        in   1        processor clock
//  rst_n      in   1        async active-low reset
//  start      in   1        pulse: IDLE->RUN, clears counters/capture
//  exp_valid  in   1        expected event offered
//  exp_ready  out  1        queue not full
//  exp_kind   in   1        0=reg write, 1=mem store
//  exp_addr   in   MADDR_W  reg index (low RADDR_W bits) or mem address
//  exp_data   in   DATA_W   expected value
//  exp_close  in   1        pulse: no further expected events
//  wb_we      in   1        WB register write strobe
//  wb_addr    in   RADDR_W  WB destination register
//  wb_data    in   DATA_W   WB write data
//  mem_we     in   1        data-memory store strobe
//  mem_addr   in   MADDR_W  store address
//  mem_wdata  in   DATA_W   store data
//  done       out  1        sticky: PASS or FAIL reached
//  pass       out  1        sticky pass
//  fail       out  1        sticky fail
//  err_code   out  2        0 none, 1 mismatch, 2 unexpected event, 3 timeout
//  cycle_cnt  out  16       cycles spent in RUN (saturating)
//  ev_cnt     out  8        events matched
//  fail_got   out  DATA_W   observed data at first failure
//  fail_exp   out  DATA_W   expected data at first failure
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, queue empty, closed=0, all outputs 0, exp_ready=1.
//  - States: IDLE -start-> RUN; RUN -> PASS | FAIL; PASS/FAIL -start-> RUN. Only reset clears the queue.
//  - Queue push when exp_valid&&exp_ready (IDLE or RUN). A push when full is dropped; exp_ready=0 then.
//  - exp_close latches closed=1; start does not clear closed.
//  - Observed event = wb_we with wb_addr!=0, or mem_we. Writes to reg 0 are ignored.
//  - Compare is combinational against queue head. Pop and ev_cnt++ on the next edge, 1-cycle latency to flags.
//  - A reg match requires kind=0, addr[RADDR_W-1:0]==wb_addr and data equal.
//    A mem match requires kind=1 and addr/data equal.
//  - Same cycle reg+mem: reg vs head, mem vs head+1; both must match, pop 2. If only 1 entry: mem -> unexpected.
//  - Event with queue empty -> FAIL, err 2. Mismatch -> FAIL, err 1. Capture fail_got/fail_exp once (first failure).
//  - RUN && closed && queue empty && no event this cycle -> PASS next edge.
//  - cycle_cnt==MAX_CYCLES-1 in RUN without PASS -> FAIL, err 3. FAIL beats PASS on the same edge.
//  - Events in IDLE/PASS/FAIL are ignored; counters are frozen outside RUN.
//  - cycle_cnt saturates at 16'hFFFF; ev_cnt wraps mod 256.
// CONFIGURATION
//  - CHK_MEM_EN defined: mem stores are checked as above.
//  - Undefined: mem_we ignored, kind=1 entries are popped and skipped without compare, err 2 only from reg events.
// STRUCTURE
//  - Package chk_pkg: state enum {IDLE,RUN,PASS,FAIL}, err_code localparams, event-kind constants.
//  - Sub-module chk_exp_fifo: EXP_DEPTH queue exposing head and head+1 peek, pop of 0/1/2 entries, count.
// TESTING
//  - lw/add/sw: load {reg17=0x5, reg16=0xA, mem 0xC=0xA}, close, start.
//    Drive matching events at cycles 5,6,7 -> pass=1, ev_cnt=3, err 0.
//  - Same as above but wb_data=0xB for reg16 -> fail=1, err 1, fail_got=0xB, fail_exp=0xA.
//  - Empty queue, RUN, wb_we to reg 8 -> fail, err 2.
//    Write to reg 0 instead -> no failure, stays RUN.
//  - Same-cycle reg16=0xA and mem 0xC=0xA with both queued -> pop 2, ev_cnt=2, pass.
//  - No close, MAX_CYCLES=8 -> fail, err 3 at cycle_cnt=7. Push 17 entries at depth 16 -> exp_ready=0, 17th dropped.
//  - Reset asserted mid-RUN -> all outputs 0 asynchronously, queue empty.
//    CHK_MEM_EN off: mem entry skipped, still pass.

Source files
------------

// File: rtl/chk_pkg.sv
// Shared types for the retire checker: FSM states, error codes and event kinds.
package chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } chk_state_t;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_MISMATCH   = 2'd1;
    localparam logic [1:0] ERR_UNEXPECTED = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

endpackage

// File: rtl/chk_exp_fifo.sv
// Expected-event queue: circular buffer with head and head+1 peek, pops 0, 1 or 2 entries per cycle.
module chk_exp_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       pop_n,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] head1,
    output logic [CW-1:0]    count,
    output logic             full
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;

    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign head    = store[rd_ptr];
    assign head1   = store[rd_ptr + AW'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + CW'(push_ok) - CW'(pop_n);
        end
    end

    // Payload needs no reset; only entries below count are ever looked at.
    always_ff @(posedge clk) begin
        if (push_ok)
            store[wr_ptr] <= din;
    end

endmodule

// File: rtl/retire_checker.sv
// In-order retire checker: matches WB register writes and MEM stores against a preloaded queue.
// Define CHK_MEM_EN to check stores; otherwise stores are ignored and queued store entries are skipped.
//
// state | meaning
// IDLE  | after reset, queue may be loaded, events ignored
// RUN   | comparing events, counting cycles
// PASS  | queue drained after close, sticky until start
// FAIL  | mismatch, unexpected event or timeout, sticky until start
module retire_checker
    import chk_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MADDR_W    = 32,
    parameter int RADDR_W    = 5,
    parameter int EXP_DEPTH  = 16,
    parameter int MAX_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               exp_valid,
    output logic               exp_ready,
    input  logic               exp_kind,
    input  logic [MADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0]  exp_data,
    input  logic               exp_close,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               mem_we,
    input  logic [MADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]  mem_wdata,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [1:0]         err_code,
    output logic [15:0]        cycle_cnt,
    output logic [7:0]         ev_cnt,
    output logic [DATA_W-1:0]  fail_got,
    output logic [DATA_W-1:0]  fail_exp
);

    localparam int EW = 1 + MADDR_W + DATA_W;
    localparam int CW = $clog2(EXP_DEPTH) + 1;

    chk_state_t         state, state_nx;
    logic               closed;
    logic [EW-1:0]      head, head1;
    logic [CW-1:0]      count;
    logic               full;
    logic               head_kind, head1_kind;
    logic [MADDR_W-1:0] head_addr, head1_addr;
    logic [DATA_W-1:0]  head_data, head1_data;
    logic               has1, has2;
    logic               obs_reg, obs_mem;
    logic               reg_hit0;
    logic [1:0]         pop_n, ev_inc;
    logic               fail_now;
    logic [1:0]         err_nx;
    logic [DATA_W-1:0]  got_nx, exp_nx;

    assign exp_ready = !full && (state == IDLE || state == RUN);

    chk_exp_fifo #(.WIDTH(EW), .DEPTH(EXP_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (exp_valid && exp_ready),
        .din   ({exp_kind, exp_addr, exp_data}),
        .pop_n (pop_n),
        .head  (head),
        .head1 (head1),
        .count (count),
        .full  (full)
    );

    assign {head_kind, head_addr, head_data}    = head;
    assign {head1_kind, head1_addr, head1_data} = head1;
    assign has1     = (count != '0);
    assign has2     = (count > CW'(1));
    assign obs_reg  = wb_we && (wb_addr != '0);
    assign reg_hit0 = (head_kind == KIND_REG) && (head_addr[RADDR_W-1:0] == wb_addr)
                      && (head_data == wb_data);

`ifdef CHK_MEM_EN
    logic mem_hit0, mem_hit1;
    assign obs_mem  = mem_we;
    assign mem_hit0 = (head_kind == KIND_MEM) && (head_addr == mem_addr) && (head_data == mem_wdata);
    assign mem_hit1 = (head1_kind == KIND_MEM) && (head1_addr == mem_addr) && (head1_data == mem_wdata);
`else
    logic reg_hit1;
    logic unused_mem;
    assign obs_mem    = 1'b0;
    assign reg_hit1   = (head1_kind == KIND_REG) && (head1_addr[RADDR_W-1:0] == wb_addr)
                        && (head1_data == wb_data);
    assign unused_mem = ^{mem_we, mem_addr, mem_wdata,
                          head_addr[MADDR_W-1:RADDR_W], head1_addr[MADDR_W-1:RADDR_W]};
`endif

    always_comb begin
        state_nx = state;
        pop_n    = 2'd0;
        ev_inc   = 2'd0;
        fail_now = 1'b0;
        err_nx   = ERR_NONE;
        got_nx   = '0;
        exp_nx   = '0;
        case (state)
            RUN: begin
                if (obs_reg || obs_mem) begin
`ifdef CHK_MEM_EN
                    if (obs_reg) begin
                        if (!has1) begin
                            fail_now = 1'b1;
                            err_nx   = ERR_UNEXPECTED;
                            got_nx   = wb_data;
                        end else if (!reg_hit0) begin
                            fail_now = 1'b1;
                            err_nx   = ERR_MISMATCH;
                            got_nx   = wb_data;
                            exp_nx   = head_data;
                        end
                    end
                    // A store in the same cycle as a reg write retires after it, so it meets head+1.
                    if (obs_mem && !fail_now) begin
                        if (obs_reg ? !has2 : !has1) begin
                            fail_now = 1'b1;
                            err_nx   = ERR_UNEXPECTED;
                            got_nx   = mem_wdata;
                        end else if (obs_reg ? !mem_hit1 : !mem_hit0) begin
                            fail_now = 1'b1;
                            err_nx   = ERR_MISMATCH;
                            got_nx   = mem_wdata;
                            exp_nx   = obs_reg ? head1_data : head_data;
                        end
                    end
                    if (!fail_now) begin
                        pop_n  = 2'(obs_reg) + 2'(obs_mem);
                        ev_inc = pop_n;
                    end
`else
                    // A store entry at the head is skipped, so the reg write is judged against head+1.
                    if (has1 && head_kind == KIND_MEM) begin
                        if (!has2) begin
                            fail_now = 1'b1;
                            err_nx   = ERR_UNEXPECTED;
                            got_nx   = wb_data;
                        end else if (!reg_hit1) begin
                            fail_now = 1'b1;
                            err_nx   = ERR_MISMATCH;
                            got_nx   = wb_data;
                            exp_nx   = head1_data;
                        end else begin
                            pop_n  = 2'd2;
                            ev_inc = 2'd1;
                        end
                    end else if (!has1) begin
                        fail_now = 1'b1;
                        err_nx   = ERR_UNEXPECTED;
                        got_nx   = wb_data;
                    end else if (!reg_hit0) begin
                        fail_now = 1'b1;
                        err_nx   = ERR_MISMATCH;
                        got_nx   = wb_data;
                        exp_nx   = head_data;
                    end else begin
                        pop_n  = 2'd1;
                        ev_inc = 2'd1;
                    end
`endif
                end
`ifndef CHK_MEM_EN
                else if (has1 && head_kind == KIND_MEM) begin
                    pop_n = 2'd1;
                end
`endif
                if (fail_now) begin
                    state_nx = FAIL;
                end else if (cycle_cnt == 16'(MAX_CYCLES - 1)) begin
                    state_nx = FAIL;
                    err_nx   = ERR_TIMEOUT;
                end else if (closed && !has1 && !obs_reg && !obs_mem) begin
                    state_nx = PASS;
                end
            end
            default: begin
                if (start)
                    state_nx = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            closed    <= 1'b0;
            cycle_cnt <= '0;
            ev_cnt    <= '0;
            err_code  <= ERR_NONE;
            fail_got  <= '0;
            fail_exp  <= '0;
        end else begin
            state <= state_nx;
            if (exp_close)
                closed <= 1'b1;
            if (state != RUN) begin
                if (start) begin
                    cycle_cnt <= '0;
                    ev_cnt    <= '0;
                    err_code  <= ERR_NONE;
                    fail_got  <= '0;
                    fail_exp  <= '0;
                end
            end else begin
                ev_cnt <= ev_cnt + 8'(ev_inc);
                if (state_nx == RUN) begin
                    if (cycle_cnt != 16'hFFFF)
                        cycle_cnt <= cycle_cnt + 16'd1;
                end else if (state_nx == FAIL) begin
                    err_code <= err_nx;
                    fail_got <= got_nx;
                    fail_exp <= exp_nx;
                end
            end
        end
    end

    assign pass = (state == PASS);
    assign fail = (state == FAIL);
    assign done = pass || fail;

endmodule

// File: tb/tb_retire_checker.sv
// Scoreboard bench for retire_checker: a queue-level model predicts each run's verdict, a monitor checks it.
module tb_retire_checker;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 16;
    localparam int MAXC  = 32;
    localparam int NCYC  = MAXC + 2;
`ifdef CHK_MEM_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    typedef struct packed {
        logic          kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct packed {
        logic          p;
        logic          f;
        logic [1:0]    err;
        logic [7:0]    ev;
        logic [15:0]   cyc;
        logic [DW-1:0] got;
        logic [DW-1:0] xp;
    } res_t;

    logic          clk, rst_n, start, exp_valid, exp_ready, exp_kind, exp_close;
    logic [AW-1:0] exp_addr, mem_addr;
    logic [DW-1:0] exp_data, wb_data, mem_wdata, fail_got, fail_exp;
    logic          wb_we, mem_we, done, pass, fail;
    logic [RW-1:0] wb_addr;
    logic [1:0]    err_code;
    logic [15:0]   cycle_cnt;
    logic [7:0]    ev_cnt;

    retire_checker #(
        .DATA_W(DW), .MADDR_W(AW), .RADDR_W(RW), .EXP_DEPTH(DEPTH), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_close(exp_close),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .pass(pass), .fail(fail), .err_code(err_code),
        .cycle_cnt(cycle_cnt), .ev_cnt(ev_cnt), .fail_got(fail_got), .fail_exp(fail_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    ent_t          sc_ent[$];
    bit            rv [NCYC];
    logic [RW-1:0] ra [NCYC];
    logic [DW-1:0] rd [NCYC];
    bit            mv [NCYC];
    logic [AW-1:0] ma [NCYC];
    logic [DW-1:0] md [NCYC];
    res_t          exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic bit reg_ok(input ent_t e, input logic [RW-1:0] a, input logic [DW-1:0] d);
        return (e.kind == 1'b0) && (e.addr[RW-1:0] == a) && (e.data == d);
    endfunction

    function automatic res_t mk(input bit p, input logic [1:0] e, input int ev, input int k,
                                input logic [DW-1:0] g, input logic [DW-1:0] x);
        res_t r;
        r.p = p; r.f = !p; r.err = e; r.ev = 8'(ev); r.cyc = 16'(k); r.got = g; r.xp = x;
        return r;
    endfunction

    // Retire-order model: entries leave the queue in order as events match them.
    function automatic res_t model_run(input bit closed);
        ent_t q[$];
        int ev, used, t;
        bit ro, mo, f, pc;
        logic [1:0] e;
        logic [DW-1:0] g, x;
        ev = 0;
        for (int i = 0; i < sc_ent.size() && i < DEPTH; i++) q.push_back(sc_ent[i]);
        for (int k = 0; k < MAXC; k++) begin
            ro = rv[k] && (ra[k] != '0);
            mo = MEM_EN && mv[k];
            f = 1'b0; e = 2'd0; g = '0; x = '0;
            pc = closed && (q.size() == 0) && !ro && !mo;
            if (MEM_EN) begin
                used = 0;
                if (ro) begin
                    if (q.size() == 0) begin f = 1; e = 2; g = rd[k]; end
                    else if (!reg_ok(q[0], ra[k], rd[k])) begin f = 1; e = 1; g = rd[k]; x = q[0].data; end
                    used = 1;
                end
                if (mo && !f) begin
                    if (q.size() <= used) begin f = 1; e = 2; g = md[k]; end
                    else if (!(q[used].kind && q[used].addr == ma[k] && q[used].data == md[k])) begin
                        f = 1; e = 1; g = md[k]; x = q[used].data;
                    end
                    used++;
                end
                if (!f) for (int j = 0; j < used; j++) begin void'(q.pop_front()); ev++; end
            end else begin
                t = (q.size() > 0 && q[0].kind) ? 1 : 0;
                if (ro) begin
                    if (q.size() <= t) begin f = 1; e = 2; g = rd[k]; end
                    else if (!reg_ok(q[t], ra[k], rd[k])) begin f = 1; e = 1; g = rd[k]; x = q[t].data; end
                    else begin
                        for (int j = 0; j <= t; j++) void'(q.pop_front());
                        ev++;
                    end
                end else if (t == 1) begin
                    void'(q.pop_front());
                end
            end
            if (f) return mk(0, e, ev, k, g, x);
            if (k == MAXC - 1) return mk(0, 2'd3, ev, k, '0, '0);
            if (pc) return mk(1, 2'd0, ev, k, '0, '0);
        end
        return mk(0, 2'd3, ev, MAXC - 1, '0, '0);
    endfunction

    task automatic clear_sc();
        sc_ent.delete();
        for (int k = 0; k < NCYC; k++) begin
            rv[k] = 0; ra[k] = '0; rd[k] = '0; mv[k] = 0; ma[k] = '0; md[k] = '0;
        end
    endtask

    task automatic add_ent(input logic kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ent_t e;
        e.kind = kind; e.addr = a; e.data = d;
        sc_ent.push_back(e);
    endtask

    task automatic idle_inputs();
        start = 0; exp_valid = 0; exp_kind = 0; exp_addr = '0; exp_data = '0; exp_close = 0;
        wb_we = 0; wb_addr = '0; wb_data = '0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    endtask

    task automatic drive_events(input int k);
        wb_we = rv[k]; wb_addr = ra[k]; wb_data = rd[k];
        mem_we = mv[k]; mem_addr = ma[k]; mem_wdata = md[k];
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_close();
        exp_close = 1; @(posedge clk); #1; exp_close = 0;
    endtask

    task automatic pulse_start();
        start = 1; @(posedge clk); #1; start = 0;
    endtask

    task automatic push_entries();
        for (int i = 0; i < sc_ent.size(); i++) begin
            if (i == DEPTH) check("exp_ready_full", 32'(exp_ready), 32'd0);
            exp_valid = 1; exp_kind = sc_ent[i].kind; exp_addr = sc_ent[i].addr; exp_data = sc_ent[i].data;
            @(posedge clk); #1;
        end
        exp_valid = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_err"}, 32'(err_code), 32'd0);
        check({tag, "_cycle"}, 32'(cycle_cnt), 32'd0);
        check({tag, "_ev"}, 32'(ev_cnt), 32'd0);
        check({tag, "_got"}, fail_got, 32'd0);
        check({tag, "_exp"}, fail_exp, 32'd0);
        check({tag, "_ready"}, 32'(exp_ready), 32'd1);
    endtask

    task automatic run_scenario(input bit rst, input bit close_pulse, input bit closed_model);
        if (rst) do_reset();
        push_entries();
        if (close_pulse) pulse_close();
        exp_q.push_back(model_run(closed_model));
        pulse_start();
        for (int k = 0; k < NCYC; k++) begin
            drive_events(k);
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
        check("verdict_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic gen_random(output bit closed);
        int n, k, i;
        logic [31:0] rnd;
        logic [4:0] idx;
        ent_t e;
        clear_sc();
        n = $urandom_range(1, 6);
        for (int j = 0; j < n; j++) begin
            rnd = $urandom();
            idx = 5'($urandom_range(1, 31));
            e.kind = 1'($urandom_range(0, 1));
            e.data = $urandom();
            e.addr = e.kind ? rnd : {rnd[31:5], idx};
            sc_ent.push_back(e);
        end
        k = $urandom_range(0, 2);
        i = 0;
        while (i < n) begin
            if (!sc_ent[i].kind) begin
                rv[k] = 1; ra[k] = sc_ent[i].addr[RW-1:0]; rd[k] = sc_ent[i].data;
                if ($urandom_range(0, 7) == 0) rd[k] = rd[k] ^ (32'd1 << $urandom_range(0, 31));
                if (i + 1 < n && sc_ent[i + 1].kind && $urandom_range(0, 1) == 1) begin
                    i++;
                    mv[k] = 1; ma[k] = sc_ent[i].addr; md[k] = sc_ent[i].data;
                end
            end else begin
                mv[k] = 1; ma[k] = sc_ent[i].addr; md[k] = sc_ent[i].data;
                if ($urandom_range(0, 7) == 0) md[k] = md[k] ^ (32'd1 << $urandom_range(0, 31));
            end
            i++;
            k += $urandom_range(1, 2);
        end
        if ($urandom_range(0, 4) == 0) begin
            rv[k] = 1; ra[k] = 5'($urandom_range(1, 31)); rd[k] = $urandom();
        end
        closed = ($urandom_range(0, 5) != 0);
    endtask

    // Monitor: each new verdict is popped from the scoreboard and compared field by field.
    initial begin
        res_t r;
        bit done_q;
        done_q = 0;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                check("verdict_expected", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    check("pass", 32'(pass), 32'(r.p));
                    check("fail", 32'(fail), 32'(r.f));
                    check("err_code", 32'(err_code), 32'(r.err));
                    check("ev_cnt", 32'(ev_cnt), 32'(r.ev));
                    check("cycle_cnt", 32'(cycle_cnt), 32'(r.cyc));
                    check("fail_got", fail_got, r.got);
                    check("fail_exp", fail_exp, r.xp);
                end
            end
            done_q = done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit cl;
        rst_n = 0;
        idle_inputs();
        clear_sc();
        #1;
        check_reset_outputs("reset");
        #2;
        rst_n = 1;
        @(posedge clk); #1;

        // lw/add/sw sequence, then restart from PASS with an empty closed queue
        clear_sc();
        add_ent(0, 32'd17, 32'h5); add_ent(0, 32'd16, 32'hA); add_ent(1, 32'hC, 32'hA);
        rv[5] = 1; ra[5] = 5'd17; rd[5] = 32'h5;
        rv[6] = 1; ra[6] = 5'd16; rd[6] = 32'hA;
        mv[7] = 1; ma[7] = 32'hC; md[7] = 32'hA;
        run_scenario(1, 1, 1);
        clear_sc();
        run_scenario(0, 0, 1);

        // data mismatch on reg16
        clear_sc();
        add_ent(0, 32'd17, 32'h5); add_ent(0, 32'd16, 32'hA); add_ent(1, 32'hC, 32'hA);
        rv[5] = 1; ra[5] = 5'd17; rd[5] = 32'h5;
        rv[6] = 1; ra[6] = 5'd16; rd[6] = 32'hB;
        mv[7] = 1; ma[7] = 32'hC; md[7] = 32'hA;
        run_scenario(1, 1, 1);

        // unexpected event on an empty queue
        clear_sc();
        rv[2] = 1; ra[2] = 5'd8; rd[2] = 32'h1234;
        run_scenario(1, 0, 0);

        // reg 0 writes are not events; without close the run times out
        clear_sc();
        for (int k = 0; k < 6; k++) begin rv[k] = 1; ra[k] = '0; rd[k] = 32'(k + 1); end
        run_scenario(1, 0, 0);

        // reg write and store in the same cycle
        clear_sc();
        add_ent(0, 32'd16, 32'hA); add_ent(1, 32'hC, 32'hA);
        rv[3] = 1; ra[3] = 5'd16; rd[3] = 32'hA;
        mv[3] = 1; ma[3] = 32'hC; md[3] = 32'hA;
        run_scenario(1, 1, 1);

        // 17 pushes into a 16-deep queue; the 17th must be dropped
        clear_sc();
        for (int i = 0; i < DEPTH + 1; i++) begin
            add_ent(0, 32'((i % 31) + 1), 32'(i * 3 + 7));
            if (i < DEPTH) begin rv[i] = 1; ra[i] = 5'((i % 31) + 1); rd[i] = 32'(i * 3 + 7); end
        end
        run_scenario(1, 1, 1);

        // asynchronous reset in the middle of a run
        clear_sc();
        do_reset();
        add_ent(0, 32'd3, 32'h33); add_ent(0, 32'd4, 32'h44); add_ent(0, 32'd5, 32'h55);
        push_entries();
        pulse_close();
        pulse_start();
        wb_we = 1; wb_addr = 5'd3; wb_data = 32'h33; @(posedge clk); #1;
        wb_we = 1; wb_addr = 5'd4; wb_data = 32'h44; @(posedge clk); #1;
        idle_inputs(); @(posedge clk); #1;
        check("pre_reset_ev", 32'(ev_cnt), 32'd2);
        rst_n = 0;
        #1;
        check_reset_outputs("midrun_reset");
        #2;
        rst_n = 1;
        @(posedge clk); #1;
        clear_sc();
        run_scenario(0, 1, 1);

        for (int s = 0; s < 25; s++) begin
            gen_random(cl);
            run_scenario(1, cl, cl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
